// File: rtl/rob_entry_queue.sv
// rtl/rob_entry_queue.sv - reorder buffer: in-order allocate, out-of-order writeback, in-order retire
`ifndef RF_ADDR_BUS_WIDTH
`define RF_ADDR_BUS_WIDTH 5
`endif
`ifndef EXC_TYPE_BUS_WIDTH
`define EXC_TYPE_BUS_WIDTH 5
`endif
`ifndef ADDR_BUS_WIDTH
`define ADDR_BUS_WIDTH 32
`endif
`ifndef DATA_BUS_WIDTH
`define DATA_BUS_WIDTH 32
`endif

module rob_entry_queue #(
    parameter int ROB_DEPTH      = 8,
    parameter int ROB_ADDR_WIDTH = 3
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             flush,
    input  logic                             alloc_en,
    input  logic                             alloc_reg_write_en,
    input  logic [`RF_ADDR_BUS_WIDTH-1:0]    alloc_reg_write_addr,
    input  logic [`EXC_TYPE_BUS_WIDTH-1:0]   alloc_exception_type,
    input  logic                             alloc_is_delayslot,
    input  logic [`ADDR_BUS_WIDTH-1:0]       alloc_pc,
    output logic                             rob_full,
    output logic [ROB_ADDR_WIDTH-1:0]        alloc_id,
    input  logic                             wb_en,
    input  logic [ROB_ADDR_WIDTH-1:0]        wb_id,
    input  logic [`DATA_BUS_WIDTH-1:0]       wb_data,
    input  logic [`EXC_TYPE_BUS_WIDTH-1:0]   wb_exception_type,
    input  logic                             commit_ready,
    output logic                             commit_en,
    output logic                             commit_reg_write_en,
    output logic [`RF_ADDR_BUS_WIDTH-1:0]    commit_reg_write_addr,
    output logic [`DATA_BUS_WIDTH-1:0]       commit_data,
    output logic [`EXC_TYPE_BUS_WIDTH-1:0]   commit_exception_type,
    output logic                             commit_is_delayslot,
    output logic [`ADDR_BUS_WIDTH-1:0]       commit_pc,
    output logic [ROB_ADDR_WIDTH:0]          rob_count
);

    localparam logic [ROB_ADDR_WIDTH:0]   CNT_FULL = (ROB_ADDR_WIDTH+1)'(ROB_DEPTH);
    localparam logic [ROB_ADDR_WIDTH:0]   CNT_ONE  = (ROB_ADDR_WIDTH+1)'(1);
    localparam logic [ROB_ADDR_WIDTH-1:0] PTR_ONE  = ROB_ADDR_WIDTH'(1);

    logic [ROB_ADDR_WIDTH-1:0] head_q;
    logic [ROB_ADDR_WIDTH-1:0] tail_q;
    logic [ROB_ADDR_WIDTH:0]   count_q;
    logic [ROB_ADDR_WIDTH:0]   count_d;
    logic [ROB_DEPTH-1:0]      valid_q;
    logic [ROB_DEPTH-1:0]      done_q;

    logic                           reg_write_en_q   [ROB_DEPTH];
    logic [`RF_ADDR_BUS_WIDTH-1:0]  reg_write_addr_q [ROB_DEPTH];
    logic [`EXC_TYPE_BUS_WIDTH-1:0] exception_type_q [ROB_DEPTH];
    logic                           is_delayslot_q   [ROB_DEPTH];
    logic [`ADDR_BUS_WIDTH-1:0]     pc_q             [ROB_DEPTH];
    logic [`DATA_BUS_WIDTH-1:0]     data_q           [ROB_DEPTH];

    logic alloc_fire;
    logic wb_fire;
    logic retire_fire;

    assign rob_full  = (count_q == CNT_FULL);
    assign alloc_id  = tail_q;
    assign rob_count = count_q;

    // All decisions use pre-edge state, so a same-cycle writeback never enables a retire
    // and never lands in a slot that is only being allocated this cycle.
    assign alloc_fire  = alloc_en && !rob_full && !flush;
    assign wb_fire     = wb_en && valid_q[wb_id] && !flush;
    assign retire_fire = commit_en && commit_ready && !flush;

    always_comb begin
        count_d = count_q;
        case ({alloc_fire, retire_fire})
            2'b10:   count_d = count_q + CNT_ONE;
            2'b01:   count_d = count_q - CNT_ONE;
            default: count_d = count_q;
        endcase
    end

    always_comb begin
        commit_en             = valid_q[head_q] && done_q[head_q];
        commit_reg_write_en   = 1'b0;
        commit_reg_write_addr = '0;
        commit_data           = '0;
        commit_exception_type = '0;
        commit_is_delayslot   = 1'b0;
        commit_pc             = '0;
        if (commit_en) begin
            commit_reg_write_en   = reg_write_en_q[head_q];
            commit_reg_write_addr = reg_write_addr_q[head_q];
            commit_data           = data_q[head_q];
            commit_exception_type = exception_type_q[head_q];
            commit_is_delayslot   = is_delayslot_q[head_q];
            commit_pc             = pc_q[head_q];
        end
    end

    // Control state: pointers, occupancy and per-entry valid/done flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else if (flush) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            valid_q <= '0;
            done_q  <= '0;
        end else begin
            if (alloc_fire) begin
                valid_q[tail_q] <= 1'b1;
                done_q[tail_q]  <= 1'b0;
                tail_q          <= tail_q + PTR_ONE;
            end
            if (wb_fire) begin
                done_q[wb_id] <= 1'b1;
            end
            // Retire last so it overrides a redundant writeback to the retiring head.
            if (retire_fire) begin
                valid_q[head_q] <= 1'b0;
                done_q[head_q]  <= 1'b0;
                head_q          <= head_q + PTR_ONE;
            end
            count_q <= count_d;
        end
    end

    // Payload storage needs no reset: it is only observed through a valid, done entry.
    always_ff @(posedge clk) begin
        if (alloc_fire) begin
            reg_write_en_q[tail_q]   <= alloc_reg_write_en;
            reg_write_addr_q[tail_q] <= alloc_reg_write_addr;
            exception_type_q[tail_q] <= alloc_exception_type;
            is_delayslot_q[tail_q]   <= alloc_is_delayslot;
            pc_q[tail_q]             <= alloc_pc;
            data_q[tail_q]           <= '0;
        end
        if (wb_fire) begin
            data_q[wb_id]           <= wb_data;
            exception_type_q[wb_id] <= exception_type_q[wb_id] | wb_exception_type;
        end
    end

endmodule
